// File: rtl/infix_to_postfix_converter_if.sv
// Request/result bundle for the shunting-yard converter: the requester drives start
// and the tagged infix array; the converter returns postfix, status and stack debug.
interface infix_to_postfix_converter_if #(
  parameter int N = 13,
  parameter int W = 16
);
  logic                       start;
  logic [1:0][N-1:0][W-1:0]   infix;
  logic [1:0][N-1:0][W-1:0]   postfix;
  logic [$clog2(N+1)-1:0]     count;
  logic                       busy;
  logic                       done;
  logic                       error;
  logic [W-1:0]               token;
  logic [W-1:0]               top;
  logic [W-1:0]               opcode;
  logic [W-1:0]               input_data;
  logic [W-1:0]               output_data;

  modport master (
    output start, infix,
    input  postfix, count, busy, done, error, token, top, opcode, input_data, output_data
  );

  modport slave (
    input  start, infix,
    output postfix, count, busy, done, error, token, top, opcode, input_data, output_data
  );
endinterface

// File: rtl/infix_to_postfix_converter.sv
// Sequential shunting-yard converter: one stack action per cycle turns a tagged infix
// token array into postfix order, then drains the operator stack.
module infix_to_postfix_converter #(
  parameter int N = 13,
  parameter int W = 16
) (
  input logic                    CLK,
  input logic                    RST,
  infix_to_postfix_converter_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [W-1:0]  OP_ADD   = W'(43);
  localparam logic [W-1:0]  OP_SUB   = W'(45);
  localparam logic [W-1:0]  OP_MUL   = W'(42);
  localparam logic [W-1:0]  OP_DIV   = W'(47);
  localparam logic [W-1:0]  LPAREN   = W'(40);
  localparam logic [W-1:0]  RPAREN   = W'(41);
  localparam logic [W-1:0]  FLAG_OP  = W'(1);
  localparam logic [W-1:0]  OPC_PUSH = W'(1);
  localparam logic [W-1:0]  OPC_POP  = W'(2);
  localparam logic [CW-1:0] SLOTS    = CW'(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [CW-1:0]            count_q, count_d;
  logic [CW-1:0]            stackPtr_q, stackPtr_d;
  logic [N-1:0][W-1:0]      stack_q, stack_d;
  logic [1:0][N-1:0][W-1:0] postfix_q, postfix_d;
  logic                     error_q, error_d;
  logic                     busy_q, done_q;
  logic [W-1:0]             token_q, token_d;
  logic [W-1:0]             top_q, top_d;
  logic [W-1:0]             opcode_q, opcode_d;
  logic [W-1:0]             pushData_q, pushData_d;
  logic [W-1:0]             popData_q, popData_d;

  logic [W-1:0]  curVal, topVal, pushVal, emitVal, emitFlag;
  logic          curIsOp, doPush, doPop, doEmit, advance;
  logic [CW-1:0] topIdx;
  logic          unusedFlagBits;

  // '(' and unknown codes rank 0 so an incoming operator never pops past a paren.
  function automatic logic [1:0] prec(input logic [W-1:0] v);
    if (v == OP_ADD || v == OP_SUB)      return 2'd1;
    else if (v == OP_MUL || v == OP_DIV) return 2'd2;
    else                                 return 2'd0;
  endfunction

  assign curVal         = bus.infix[0][idx_q];
  assign curIsOp        = bus.infix[1][idx_q][0];
  assign unusedFlagBits = ^bus.infix[1];
  assign topIdx         = stackPtr_q - CW'(1);
  assign topVal         = (stackPtr_q == '0) ? '0 : stack_q[topIdx];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    stackPtr_d = stackPtr_q;
    stack_d    = stack_q;
    postfix_d  = postfix_q;
    error_d    = error_q;
    opcode_d   = '0;
    pushData_d = '0;
    popData_d  = '0;
    doPush     = 1'b0;
    doPop      = 1'b0;
    doEmit     = 1'b0;
    advance    = 1'b0;
    pushVal    = '0;
    emitVal    = '0;
    emitFlag   = '0;

    if (bus.start) begin
      state_d    = SCAN;
      idx_d      = '0;
      count_d    = '0;
      stackPtr_d = '0;
      stack_d    = '0;
      postfix_d  = '0;
      error_d    = 1'b0;
    end else begin
      unique case (state_q)
        SCAN: begin
          if (!curIsOp) begin
            doEmit  = 1'b1;
            emitVal = curVal;
            advance = 1'b1;
          end else if (curVal == '0) begin
            state_d = DRAIN;
          end else if (curVal == LPAREN) begin
            doPush  = 1'b1;
            pushVal = curVal;
            advance = 1'b1;
          end else if (curVal == RPAREN) begin
            if (stackPtr_q == '0) begin
              error_d = 1'b1;
              advance = 1'b1;
            end else if (topVal == LPAREN) begin
              doPop   = 1'b1;
              advance = 1'b1;
            end else begin
              doPop    = 1'b1;
              doEmit   = 1'b1;
              emitVal  = topVal;
              emitFlag = FLAG_OP;
            end
          end else if (prec(curVal) != 2'd0) begin
            if (prec(topVal) >= prec(curVal)) begin
              doPop    = 1'b1;
              doEmit   = 1'b1;
              emitVal  = topVal;
              emitFlag = FLAG_OP;
            end else begin
              doPush  = 1'b1;
              pushVal = curVal;
              advance = 1'b1;
            end
          end else begin
            error_d = 1'b1;
            advance = 1'b1;
          end
        end
        DRAIN: begin
          if (stackPtr_q == '0) begin
            state_d = DONE;
          end else begin
            doPop = 1'b1;
            if (topVal == LPAREN) begin
              error_d = 1'b1;
            end else begin
              doEmit   = 1'b1;
              emitVal  = topVal;
              emitFlag = FLAG_OP;
            end
          end
        end
        default: ;
      endcase

      if (advance) begin
        if (idx_q == LAST_IDX) state_d = DRAIN;
        else                   idx_d   = idx_q + IW'(1);
      end

      if (doPop) begin
        stack_d[topIdx] = '0;
        stackPtr_d      = topIdx;
        opcode_d        = OPC_POP;
        popData_d       = topVal;
      end

      // A push onto a full stack is dropped and flagged rather than wrapping.
      if (doPush) begin
        if (stackPtr_q == SLOTS) begin
          error_d = 1'b1;
        end else begin
          stack_d[stackPtr_q] = pushVal;
          stackPtr_d          = stackPtr_q + CW'(1);
          opcode_d            = OPC_PUSH;
          pushData_d          = pushVal;
        end
      end

      if (doEmit && count_q != SLOTS) begin
        postfix_d[0][count_q] = emitVal;
        postfix_d[1][count_q] = emitFlag;
        count_d               = count_q + CW'(1);
      end
    end

    token_d = (state_d == SCAN) ? bus.infix[0][idx_d] : '0;
    top_d   = (stackPtr_d == '0) ? '0 : stack_d[stackPtr_d - CW'(1)];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      count_q    <= '0;
      stackPtr_q <= '0;
      stack_q    <= '0;
      postfix_q  <= '0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      token_q    <= '0;
      top_q      <= '0;
      opcode_q   <= '0;
      pushData_q <= '0;
      popData_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      stackPtr_q <= stackPtr_d;
      stack_q    <= stack_d;
      postfix_q  <= postfix_d;
      error_q    <= error_d;
      busy_q     <= (state_d == SCAN) || (state_d == DRAIN);
      done_q     <= (state_d == DONE);
      token_q    <= token_d;
      top_q      <= top_d;
      opcode_q   <= opcode_d;
      pushData_q <= pushData_d;
      popData_q  <= popData_d;
    end
  end

  assign bus.postfix     = postfix_q;
  assign bus.count       = count_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.token       = token_q;
  assign bus.top         = top_q;
  assign bus.opcode      = opcode_q;
  assign bus.input_data  = pushData_q;
  assign bus.output_data = popData_q;
endmodule

// File: tb/tb_infix_to_postfix_converter.sv
// Directed, table-driven bench for the shunting-yard converter with hand-computed
// postfix results, latencies and a few multi-cycle restart/reset sequences.
module tb_infix_to_postfix_converter;
  localparam int N = 13;
  localparam int W = 16;

  typedef int slotArr_t [N];
  typedef struct {
    string    name;
    slotArr_t vals;
    slotArr_t flags;
    slotArr_t expVals;
    slotArr_t expFlags;
    int       expCount;
    int       expErr;
    int       expLat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errorCount = 0;
  int   checkCount = 0;
  int   latency;
  vec_t vecs [5];
  logic [W-1:0] firstToken;
  logic [W-1:0] opLog[$];
  logic [W-1:0] pushLog[$];
  logic [W-1:0] popLog[$];
  logic [W-1:0] topLog[$];

  infix_to_postfix_converter_if #(.N(N), .W(W)) ifc ();

  infix_to_postfix_converter #(.N(N), .W(W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic pulseStart(input int k);
    @(negedge clk);
    for (int s = 0; s < N; s++) begin
      ifc.infix[0][s] = W'(vecs[k].vals[s]);
      ifc.infix[1][s] = W'(vecs[k].flags[s]);
    end
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    ifc.start  = 1'b0;
    firstToken = ifc.token;
  endtask

  // Counts edges after the start edge until done, logging stack debug per edge.
  task automatic applyStimulus(input int k);
    pulseStart(k);
    opLog.delete();
    pushLog.delete();
    popLog.delete();
    topLog.delete();
    latency = 0;
    while (ifc.done !== 1'b1 && latency < 200) begin
      @(posedge clk);
      #1;
      latency++;
      opLog.push_back(ifc.opcode);
      pushLog.push_back(ifc.input_data);
      popLog.push_back(ifc.output_data);
      topLog.push_back(ifc.top);
    end
  endtask

  task automatic checkResult(input int k);
    string n;
    n = vecs[k].name;
    for (int s = 0; s < N; s++) begin
      checkOutput($sformatf("%s value[%0d]", n, s), ifc.postfix[0][s], W'(vecs[k].expVals[s]));
      checkOutput($sformatf("%s flag[%0d]", n, s), ifc.postfix[1][s], W'(vecs[k].expFlags[s]));
    end
    checkOutput({n, " count"}, W'(ifc.count), W'(vecs[k].expCount));
    checkOutput({n, " error"}, W'(ifc.error), W'(vecs[k].expErr));
    checkOutput({n, " latency"}, W'(latency), W'(vecs[k].expLat));
    checkOutput({n, " busy after done"}, W'(ifc.busy), W'(0));
    checkOutput({n, " top after done"}, ifc.top, W'(0));
    checkOutput({n, " first token"}, firstToken, W'(vecs[k].vals[0]));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " postfix"}, W'(|ifc.postfix), W'(0));
    checkOutput({tag, " count"}, W'(ifc.count), W'(0));
    checkOutput({tag, " busy"}, W'(ifc.busy), W'(0));
    checkOutput({tag, " done"}, W'(ifc.done), W'(0));
    checkOutput({tag, " error"}, W'(ifc.error), W'(0));
    checkOutput({tag, " token"}, ifc.token, W'(0));
    checkOutput({tag, " top"}, ifc.top, W'(0));
    checkOutput({tag, " opcode"}, ifc.opcode, W'(0));
    checkOutput({tag, " input_data"}, ifc.input_data, W'(0));
    checkOutput({tag, " output_data"}, ifc.output_data, W'(0));
  endtask

  initial begin
    int popIdx;
    int pushIdx;

    vecs[0].name     = "ref";
    vecs[0].vals     = '{-4, 45, 40, 42, 42, 43, 45, 40, 41, 43, 40, 41, 41};
    vecs[0].flags    = '{0, 1, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 1};
    vecs[0].expVals  = '{-4, 42, 43, 42, 41, 40, 43, 45, 45, 0, 0, 0, 0};
    vecs[0].expFlags = '{0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    vecs[0].expCount = 9;  vecs[0].expErr = 0; vecs[0].expLat = 18;

    vecs[1].name     = "1+2*3";
    vecs[1].vals     = '{1, 43, 2, 42, 3, 0, 9, 9, 9, 9, 9, 9, 9};
    vecs[1].flags    = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[1].expVals  = '{1, 2, 3, 42, 43, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1].expFlags = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1].expCount = 5;  vecs[1].expErr = 0; vecs[1].expLat = 9;

    vecs[2].name     = "8/2-1";
    vecs[2].vals     = '{8, 47, 2, 45, 1, 0, 9, 9, 9, 9, 9, 9, 9};
    vecs[2].flags    = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[2].expVals  = '{8, 2, 47, 1, 45, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2].expFlags = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2].expCount = 5;  vecs[2].expErr = 0; vecs[2].expLat = 9;

    vecs[3].name     = "(5+3";
    vecs[3].vals     = '{40, 5, 43, 3, 0, 9, 9, 9, 9, 9, 9, 9, 9};
    vecs[3].flags    = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3].expVals  = '{5, 3, 43, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3].expFlags = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3].expCount = 3;  vecs[3].expErr = 1; vecs[3].expLat = 8;

    vecs[4].name     = "2%3";
    vecs[4].vals     = '{2, 37, 3, 0, 9, 9, 9, 9, 9, 9, 9, 9, 9};
    vecs[4].flags    = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4].expVals  = '{2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4].expFlags = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4].expCount = 2;  vecs[4].expErr = 1; vecs[4].expLat = 5;

    rst       = 1'b1;
    ifc.start = 1'b0;
    ifc.infix = '0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle done after reset", W'(ifc.done), W'(0));

    // Successive starts issued from DONE also exercise back-to-back clearing.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(k);
      checkResult(k);
      if (k == 0) begin
        checkOutput("ref edge2 opcode", opLog[1], W'(1));
        checkOutput("ref edge2 input_data", pushLog[1], W'(45));
        checkOutput("ref edge2 top", topLog[1], W'(45));
        checkOutput("ref edge7 opcode", opLog[6], W'(2));
        checkOutput("ref edge7 output_data", popLog[6], W'(42));
        checkOutput("ref edge7 top", topLog[6], W'(40));
      end
      if (k == 2) begin
        popIdx  = -1;
        pushIdx = -1;
        for (int i = 0; i < opLog.size(); i++) begin
          if (popIdx < 0 && opLog[i] == W'(2) && popLog[i] == W'(47)) popIdx = i;
          if (pushIdx < 0 && opLog[i] == W'(1) && pushLog[i] == W'(45)) pushIdx = i;
        end
        checkOutput("8/2-1 pop 47 before push 45", W'(popIdx >= 0 && pushIdx > popIdx), W'(1));
      end
    end

    // Restart while busy: partial reference result must vanish.
    pulseStart(0);
    repeat (4) @(posedge clk);
    applyStimulus(1);
    checkResult(1);

    // Asynchronous reset in the middle of SCAN.
    pulseStart(0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("mid-scan reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post-reset idle busy", W'(ifc.busy), W'(0));
    checkOutput("post-reset idle done", W'(ifc.done), W'(0));
    applyStimulus(3);
    checkResult(3);
    applyStimulus(0);
    checkResult(0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/infix_to_postfix_converter.md
# infix_to_postfix_converter

Sequential shunting-yard converter for the stack-based ALU front end. It takes a fixed-length array of tagged infix tokens (numbers and ASCII operator/parenthesis codes), reorders them into postfix (RPN) using an internal operator stack, and presents the postfix array for the downstream stack evaluator. Stack activity is exported on debug ports for bench observation.

## Interface
Parameters:
- N, 13, number of token slots in the infix and postfix arrays; also the operator-stack depth
- W, 16, token value width

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a conversion
- infix  input  [1:0][N-1:0][W-1:0]  plane 0 holds values; plane 1 holds type flags (bit 0: 1 = operator/paren, 0 = number); sampled every cycle, must be held stable until done
- postfix  output  [1:0][N-1:0][W-1:0]  same encoding; slots at or beyond count are 0 in both planes
- count  output  $clog2(N+1)  number of valid postfix tokens
- busy  output  1  conversion in progress
- done  output  1  high in DONE until the next start
- error  output  1  sticky until next start: unmatched paren, unknown operator code, or stack overflow
- token  output  W  infix value plane at the current scan index (0 outside SCAN)
- top  output  W  current stack top value (0 when empty)
- opcode  output  W  stack operation this cycle: 0 NOP, 1 PUSH, 2 POP
- input_data  output  W  value pushed this cycle (0 otherwise)
- output_data  output  W  value popped this cycle (0 otherwise)

## Operation
- Operator codes: '+' 43 and '-' 45 have precedence 1; '*' 42 and '/' 47 have precedence 2; all are left-associative. '(' is 40, ')' is 41. An operator token with value 0 terminates the expression early. Any other operator code sets error and is skipped.
- Numbers are signed two's-complement values and are copied verbatim, for example -4.
- States: IDLE, SCAN, DRAIN, DONE. start is honoured in any state. It clears postfix, count, the stack, error and index i, then enters SCAN.
- SCAN performs exactly one action per cycle on token i:
  - Number: emit to postfix[count], count++, i++.
  - '(': push, i++.
  - ')': if the top is '(', pop it (discarded) and i++. If the top is an operator, pop and emit it; i unchanged. If the stack is empty, set error and i++.
  - Operator: while the top is an operator with precedence >= the token's precedence, pop and emit it, one per cycle, with i unchanged. Otherwise push and i++.
  - After the cycle that consumes slot N-1, or on the terminator, the next state is DRAIN.
- DRAIN: each cycle pops one entry. Operators are emitted. A '(' is discarded and sets error. When the stack is empty, go to DONE with no pop that cycle.
- Push when N entries are already on the stack: push is dropped and error is set.
- busy is high in SCAN and DRAIN.

## Timing
- All outputs are registered. Reset clears every output and the stack to 0 and enters IDLE.
- RST asserted mid-conversion aborts immediately to IDLE with all outputs 0.
- Latency from the start edge: one edge per SCAN action, plus one edge per DRAIN pop, plus one final empty-check edge. done rises after that final edge.
- start while busy restarts the conversion. The partial result is lost.

## Test plan
- Reference expression -4-(42*43-(41+40)), with flags 0,1,1,0,1,0,1,1,0,1,0,1,1 and N=13:
  - Postfix values: -4, 42, 43, '*', 41, 40, '+', '-', '-'.
  - Flags: 0,0,0,1,0,0,1,1,1. count = 9, error = 0.
  - done rises 18 edges after the start edge. Slots 9..12 are 0.
- 1+2*3 terminated by op value 0 -> postfix 1 2 3 * +, count 5.
- 8/2-1 (left associativity) -> postfix 8 2 / 1 -, count 5. Check opcode shows POP with output_data 47 before PUSH of 45.
- Unbalanced input '(' 5 '+' 3 with no closing paren -> postfix 5 3 +, count 3, error = 1.
- RST pulse mid-SCAN -> all outputs 0 and IDLE. A following start converts correctly.
- Back-to-back: start asserted in DONE with new infix data -> outputs are cleared and the new result is correct.
